tx_cmd_sched: RTL and testbench

UART command controller and burst scheduler for the 9 Mbit/s transmitter. Parses framed command bytes from the MCU UART receiver, updates the transmit pattern and burst length, and starts or stops bursts. Counts transmitted bits, ends each burst after the programmed count, and returns one ACK/NAK byte per valid frame to the UART transmitter. Sits between uart_mcu and the tx datapath in the 25 MHz domain; bit_tick arrives already synchronized.

---
 rtl/tx_cmd_sched.sv | 169 ++++++++++++++++
 tb/tb_tx_cmd_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_cmd_sched.sv
// UART command parser and burst scheduler: decodes framed commands from the MCU,
// programs pattern/burst length, runs bit-counted bursts and answers ACK/NAK.
module tx_cmd_sched #(
   parameter logic [7:0]  DEFAULT_PATTERN = 8'hAA,
   parameter logic [31:0] DEFAULT_COUNT   = 32'd9_000_000,
   parameter int unsigned TIMEOUT_CYC     = 250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        from_uart_valid,
   input  logic [7:0]  from_uart_data,
   output logic [7:0]  to_uart_data,
   output logic        to_uart_valid,
   input  logic        to_uart_ready,
   input  logic        bit_tick,
   output logic [7:0]  reg_data,
   output logic [31:0] max_tx_count,
   output logic        tx_enable,
   output logic        max_tx_flag,
   output logic        busy
);

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam logic [7:0] ACK_BYTE    = 8'h06;
   localparam logic [7:0] NAK_BYTE    = 8'h15;
   localparam logic [7:0] CMD_PATTERN = 8'h01;
   localparam logic [7:0] CMD_COUNT   = 8'h02;
   localparam logic [7:0] CMD_START   = 8'h03;
   localparam logic [7:0] CMD_STOP    = 8'h04;

   localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_HUNT,
      S_CMD,
      S_DATA,
      S_CHK,
      S_EXEC,
      S_RESP
   } state_t;

   state_t        state;
   logic [7:0]    cmd;
   logic [31:0]   data_sr;
   logic [7:0]    chk_acc;
   logic [1:0]    idx;
   logic          nak_force;
   logic [TW-1:0] tmo_cnt;
   logic [31:0]   tx_bit_cnt;
   logic          exec_ack;

   always_comb begin
      exec_ack = 1'b0;
      if (!nak_force) begin
         case (cmd)
            CMD_PATTERN: exec_ack = 1'b1;
            CMD_COUNT:   exec_ack = !tx_enable;
            CMD_START:   exec_ack = (max_tx_count != '0);
            CMD_STOP:    exec_ack = 1'b1;
            default:     exec_ack = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_HUNT;
         cmd           <= '0;
         data_sr       <= '0;
         chk_acc       <= '0;
         idx           <= '0;
         nak_force     <= 1'b0;
         tmo_cnt       <= '0;
         tx_bit_cnt    <= '0;
         reg_data      <= DEFAULT_PATTERN;
         max_tx_count  <= DEFAULT_COUNT;
         tx_enable     <= 1'b0;
         max_tx_flag   <= 1'b0;
         to_uart_valid <= 1'b0;
         to_uart_data  <= '0;
         busy          <= 1'b0;
      end else begin
         // Burst counting first so that a START/STOP executing on the final tick overrides it.
         if (bit_tick && tx_enable) begin
            if (tx_bit_cnt == max_tx_count - 32'd1) begin
               tx_enable   <= 1'b0;
               max_tx_flag <= 1'b1;
               tx_bit_cnt  <= '0;
            end else begin
               tx_bit_cnt <= tx_bit_cnt + 32'd1;
            end
         end

         case (state)
            S_HUNT: begin
               if (from_uart_valid && from_uart_data == SYNC_BYTE) begin
                  state   <= S_CMD;
                  busy    <= 1'b1;
                  tmo_cnt <= '0;
               end
            end

            S_CMD, S_DATA, S_CHK: begin
               if (from_uart_valid) begin
                  tmo_cnt <= '0;
                  case (state)
                     S_CMD: begin
                        cmd       <= from_uart_data;
                        chk_acc   <= from_uart_data;
                        idx       <= '0;
                        nak_force <= 1'b0;
                        state     <= S_DATA;
                     end
                     S_DATA: begin
                        data_sr <= {data_sr[23:0], from_uart_data};
                        chk_acc <= chk_acc ^ from_uart_data;
                        idx     <= idx + 2'd1;
                        if (idx == 2'd3) state <= S_CHK;
                     end
                     default: begin
                        nak_force <= (from_uart_data != chk_acc);
                        state     <= S_EXEC;
                     end
                  endcase
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= S_HUNT;
                  busy  <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            S_EXEC: begin
               to_uart_data  <= exec_ack ? ACK_BYTE : NAK_BYTE;
               to_uart_valid <= 1'b1;
               state         <= S_RESP;
               if (exec_ack) begin
                  case (cmd)
                     CMD_PATTERN: reg_data <= data_sr[7:0];
                     CMD_COUNT:   max_tx_count <= data_sr;
                     CMD_START: begin
                        tx_bit_cnt  <= '0;
                        tx_enable   <= 1'b1;
                        max_tx_flag <= 1'b0;
                     end
                     CMD_STOP:    tx_enable <= 1'b0;
                     default: ;
                  endcase
               end
            end

            S_RESP: begin
               if (to_uart_ready) begin
                  to_uart_valid <= 1'b0;
                  state         <= S_HUNT;
                  busy          <= 1'b0;
               end
            end

            default: begin
               state <= S_HUNT;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_cmd_sched.sv
// Directed bench for tx_cmd_sched: table of command frames plus burst, handshake,
// same-cycle tick, timeout and reset corner sequences.
module tb_tx_cmd_sched;

   localparam int unsigned TMO = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        from_uart_valid;
   logic [7:0]  from_uart_data;
   logic [7:0]  to_uart_data;
   logic        to_uart_valid;
   logic        to_uart_ready;
   logic        bit_tick;
   logic [7:0]  reg_data;
   logic [31:0] max_tx_count;
   logic        tx_enable;
   logic        max_tx_flag;
   logic        busy;

   int tests = 0;
   int fails = 0;

   tx_cmd_sched #(.TIMEOUT_CYC(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .from_uart_valid (from_uart_valid),
      .from_uart_data  (from_uart_data),
      .to_uart_data    (to_uart_data),
      .to_uart_valid   (to_uart_valid),
      .to_uart_ready   (to_uart_ready),
      .bit_tick        (bit_tick),
      .reg_data        (reg_data),
      .max_tx_count    (max_tx_count),
      .tx_enable       (tx_enable),
      .max_tx_flag     (max_tx_flag),
      .busy            (busy)
   );

   always #20 clk = ~clk;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] data;
      bit          bad;
      logic [7:0]  resp;
      logic [7:0]  exp_reg;
      logic [31:0] exp_cnt;
      logic        exp_en;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      from_uart_valid = 1'b1;
      from_uart_data  = b;
   endtask

   // Returns at the falling edge just after the CHK byte was taken (parser now in EXEC).
   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d, input bit bad);
      logic [7:0] chk;
      chk = cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
      if (bad) chk = chk ^ 8'hFF;
      send_byte(8'hA5);
      send_byte(cmd);
      send_byte(d[31:24]);
      send_byte(d[23:16]);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
      send_byte(chk);
      @(negedge clk);
      from_uart_valid = 1'b0;
   endtask

   task automatic do_frame(input string name, input logic [7:0] cmd, input logic [31:0] d,
                           input bit bad, input bit tick_in_exec, input logic [7:0] exp_resp);
      send_frame(cmd, d, bad);
      check({name, "_early"}, to_uart_valid, 1'b0);
      bit_tick = tick_in_exec;
      @(negedge clk);
      bit_tick = 1'b0;
      check({name, "_valid"}, to_uart_valid, 1'b1);
      check({name, "_resp"}, to_uart_data, exp_resp);
      @(negedge clk);
      check({name, "_one_byte"}, to_uart_valid, 1'b0);
   endtask

   task automatic tick_once();
      @(negedge clk);
      bit_tick = 1'b1;
      @(negedge clk);
      bit_tick = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{8'h01, 32'h0000_003C, 1'b0, 8'h06, 8'h3C, 32'd9_000_000, 1'b0};
      vecs[1]  = '{8'h01, 32'h0000_0055, 1'b1, 8'h15, 8'h3C, 32'd9_000_000, 1'b0};
      vecs[2]  = '{8'h02, 32'h0000_0005, 1'b0, 8'h06, 8'h3C, 32'd5,         1'b0};
      vecs[3]  = '{8'h07, 32'h1234_5678, 1'b0, 8'h15, 8'h3C, 32'd5,         1'b0};
      vecs[4]  = '{8'h04, 32'h0000_0000, 1'b0, 8'h06, 8'h3C, 32'd5,         1'b0};
      vecs[5]  = '{8'h02, 32'h0000_0000, 1'b0, 8'h06, 8'h3C, 32'd0,         1'b0};
      vecs[6]  = '{8'h03, 32'h0000_0000, 1'b0, 8'h15, 8'h3C, 32'd0,         1'b0};
      vecs[7]  = '{8'h02, 32'h0000_0005, 1'b0, 8'h06, 8'h3C, 32'd5,         1'b0};
      vecs[8]  = '{8'h03, 32'h0000_0000, 1'b0, 8'h06, 8'h3C, 32'd5,         1'b1};
      vecs[9]  = '{8'h02, 32'h0000_0009, 1'b0, 8'h15, 8'h3C, 32'd5,         1'b1};
      vecs[10] = '{8'h04, 32'h0000_0000, 1'b0, 8'h06, 8'h3C, 32'd5,         1'b0};

      rst             = 1'b0;
      from_uart_valid = 1'b0;
      from_uart_data  = '0;
      to_uart_ready   = 1'b1;
      bit_tick        = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      check("rst_reg_data", reg_data, 8'hAA);
      check("rst_count", max_tx_count, 32'd9_000_000);
      check("rst_tx_enable", tx_enable, 1'b0);
      check("rst_flag", max_tx_flag, 1'b0);
      check("rst_valid", to_uart_valid, 1'b0);
      check("rst_resp_data", to_uart_data, 8'h00);
      check("rst_busy", busy, 1'b0);

      for (int i = 0; i < 11; i++) begin
         do_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].data, vecs[i].bad, 1'b0, vecs[i].resp);
         check($sformatf("vec%0d_reg", i), reg_data, vecs[i].exp_reg);
         check($sformatf("vec%0d_cnt", i), max_tx_count, vecs[i].exp_cnt);
         check($sformatf("vec%0d_en", i), tx_enable, vecs[i].exp_en);
         check($sformatf("vec%0d_busy", i), busy, 1'b0);
      end

      // Burst of 5 with 7 ticks offered.
      do_frame("burst_start", 8'h03, 32'h0, 1'b0, 1'b0, 8'h06);
      check("burst_en0", tx_enable, 1'b1);
      for (int t = 1; t <= 7; t++) begin
         tick_once();
         check($sformatf("burst_en_t%0d", t), tx_enable, (t < 5) ? 1'b1 : 1'b0);
         check($sformatf("burst_flag_t%0d", t), max_tx_flag, (t >= 5) ? 1'b1 : 1'b0);
      end

      // Response held while the UART transmitter is stalled.
      do_frame("hold_start", 8'h03, 32'h0, 1'b0, 1'b0, 8'h06);
      check("hold_flag_clr", max_tx_flag, 1'b0);
      to_uart_ready = 1'b0;
      send_frame(8'h02, 32'h0000_0009, 1'b0);
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
         check($sformatf("hold_c%0d", c), {23'd0, to_uart_valid, to_uart_data}, 32'h115);
         @(negedge clk);
      end
      to_uart_ready = 1'b1;
      @(negedge clk);
      check("hold_released", to_uart_valid, 1'b0);
      check("hold_busy", busy, 1'b0);
      check("hold_cnt", max_tx_count, 32'd5);
      do_frame("hold_stop", 8'h04, 32'h0, 1'b0, 1'b0, 8'h06);

      // START executing on the final tick restarts the burst.
      do_frame("sw_cnt2", 8'h02, 32'h0000_0002, 1'b0, 1'b0, 8'h06);
      do_frame("sw_start", 8'h03, 32'h0, 1'b0, 1'b0, 8'h06);
      tick_once();
      do_frame("sw_restart", 8'h03, 32'h0, 1'b0, 1'b1, 8'h06);
      check("sw_en", tx_enable, 1'b1);
      check("sw_flag", max_tx_flag, 1'b0);
      tick_once();
      check("sw_en_t1", tx_enable, 1'b1);
      tick_once();
      check("sw_en_t2", tx_enable, 1'b0);
      check("sw_flag_t2", max_tx_flag, 1'b1);

      // STOP executing on the final tick still records completion.
      do_frame("sp_start", 8'h03, 32'h0, 1'b0, 1'b0, 8'h06);
      tick_once();
      do_frame("sp_stop", 8'h04, 32'h0, 1'b0, 1'b1, 8'h06);
      check("sp_en", tx_enable, 1'b0);
      check("sp_flag", max_tx_flag, 1'b1);

      // Partial frame abandoned by the inter-byte timeout.
      begin
         logic seen;
         seen = 1'b0;
         send_byte(8'hA5);
         send_byte(8'h01);
         send_byte(8'h00);
         @(negedge clk);
         from_uart_valid = 1'b0;
         check("tmo_busy_during", busy, 1'b1);
         for (int c = 0; c < int'(TMO) + 1; c++) begin
            @(negedge clk);
            seen = seen | to_uart_valid;
         end
         check("tmo_no_resp", seen, 1'b0);
         check("tmo_busy_after", busy, 1'b0);
         check("tmo_reg", reg_data, 8'h3C);
      end
      do_frame("tmo_full", 8'h01, 32'h0000_005A, 1'b0, 1'b0, 8'h06);
      check("tmo_full_reg", reg_data, 8'h5A);

      // Reset in the middle of a burst and a frame.
      do_frame("rs_start", 8'h03, 32'h0, 1'b0, 1'b0, 8'h06);
      send_byte(8'hA5);
      send_byte(8'h01);
      @(negedge clk);
      from_uart_valid = 1'b0;
      rst = 1'b0;
      #5;
      check("rs_en", tx_enable, 1'b0);
      check("rs_reg", reg_data, 8'hAA);
      check("rs_cnt", max_tx_count, 32'd9_000_000);
      check("rs_busy", busy, 1'b0);
      check("rs_valid", to_uart_valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rs_valid_after", to_uart_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
